// File: rtl/uart_pkg.sv
// Shared FSM state type, 8N1 frame constants and the bit-period helper
// used by the UART top level and its bit timer.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int   DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  function automatic int calcClksPerBit(input int clkFreq, input int baudRate);
    return clkFreq / baudRate;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter with an end-of-bit tick and a mid-bit tick.
// Holding i_clear keeps the count at zero, so a new bit period starts on release.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic i_clk,
  input  logic i_rstN,
  input  logic i_clear,
  output logic o_tickEnd,
  output logic o_tickMid
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] END_VAL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] MID_VAL = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic [CNT_W-1:0] r_cnt;

  // Wrapping at END_VAL lets consecutive bits be timed without a reload.
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_cnt <= '0;
    end else if (i_clear || o_tickEnd) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tickEnd = (r_cnt == END_VAL);
  assign o_tickMid = (r_cnt == MID_VAL);

endmodule

// File: rtl/uart_top.sv
// Full-duplex 8N1 UART: independent TX and RX state machines, each paced
// by its own uart_bit_timer, with a 2-flop synchroniser on the rx pin.
module uart_top
  import uart_pkg::*;
#(
  parameter int clk_freq  = 1000000,
  parameter int baud_rate = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic [7:0] dintx,
  input  logic       send,
  output logic       tx,
  output logic [7:0] doutrx,
  output logic       donetx,
  output logic       donerx
);

  localparam int CLKS_PER_BIT = calcClksPerBit(clk_freq, baud_rate);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 4) begin : g_cpbCheck
    $error("uart_top: clk_freq/baud_rate must give at least 4 clocks per bit");
  end

  // ---------------- Transmitter ----------------
  uart_state_t r_txState, w_txNext;
  logic [7:0]  r_txShift;
  logic [2:0]  r_txBitIdx;
  logic        w_txLoad, w_tx, w_doneTx, w_txClear;
  logic        w_txTickEnd, w_txMidUnused;

  assign w_txClear = (r_txState == IDLE);

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_txTimer (
    .i_clk    (clk),
    .i_rstN   (rst),
    .i_clear  (w_txClear),
    .o_tickEnd(w_txTickEnd),
    .o_tickMid(w_txMidUnused)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_txState <= IDLE;
    end else begin
      r_txState <= w_txNext;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_txShift  <= '0;
      r_txBitIdx <= '0;
    end else begin
      if (w_txLoad) begin
        r_txShift <= dintx;
      end else if (r_txState == DATA && w_txTickEnd) begin
        r_txShift <= {1'b0, r_txShift[7:1]};
      end
      if (r_txState != DATA) begin
        r_txBitIdx <= '0;
      end else if (w_txTickEnd) begin
        r_txBitIdx <= r_txBitIdx + 1'b1;
      end
    end
  end

  // A send still high at the end of STOP chains straight into the next START.
  always_comb begin
    w_txNext = r_txState;
    w_txLoad = 1'b0;
    w_tx     = STOP_BIT;
    w_doneTx = 1'b0;
    case (r_txState)
      IDLE: begin
        if (send) begin
          w_txNext = START;
          w_txLoad = 1'b1;
        end
      end
      START: begin
        w_tx = START_BIT;
        if (w_txTickEnd) w_txNext = DATA;
      end
      DATA: begin
        w_tx = r_txShift[0];
        if (w_txTickEnd && r_txBitIdx == LAST_BIT) w_txNext = STOP;
      end
      STOP: begin
        w_tx = STOP_BIT;
        if (w_txTickEnd) begin
          w_doneTx = 1'b1;
          if (send) begin
            w_txNext = START;
            w_txLoad = 1'b1;
          end else begin
            w_txNext = IDLE;
          end
        end
      end
      default: w_txNext = IDLE;
    endcase
  end

  assign tx     = w_tx;
  assign donetx = w_doneTx;

  // ---------------- Receiver ----------------
  uart_state_t r_rxState, w_rxNext;
  logic        r_rxMeta, r_rxSync;
  logic [7:0]  r_rxShift, r_doutRx;
  logic [2:0]  r_rxBitIdx;
  logic        r_doneRx;
  logic        w_rxClear, w_rxShiftEn, w_rxFrameOk;
  logic        w_rxTickEnd, w_rxTickMid;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rxTimer (
    .i_clk    (clk),
    .i_rstN   (rst),
    .i_clear  (w_rxClear),
    .o_tickEnd(w_rxTickEnd),
    .o_tickMid(w_rxTickMid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rxMeta  <= 1'b1;
      r_rxSync  <= 1'b1;
      r_rxState <= IDLE;
    end else begin
      r_rxMeta  <= rx;
      r_rxSync  <= r_rxMeta;
      r_rxState <= w_rxNext;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rxShift  <= '0;
      r_rxBitIdx <= '0;
      r_doutRx   <= '0;
      r_doneRx   <= 1'b0;
    end else begin
      r_doneRx <= w_rxFrameOk;
      if (w_rxShiftEn) r_rxShift <= {r_rxSync, r_rxShift[7:1]};
      if (r_rxState != DATA) begin
        r_rxBitIdx <= '0;
      end else if (w_rxShiftEn) begin
        r_rxBitIdx <= r_rxBitIdx + 1'b1;
      end
      if (w_rxFrameOk) r_doutRx <= r_rxShift;
    end
  end

  // Re-centring the timer at mid start bit makes every later end tick a bit centre.
  always_comb begin
    w_rxNext    = r_rxState;
    w_rxClear   = 1'b0;
    w_rxShiftEn = 1'b0;
    w_rxFrameOk = 1'b0;
    case (r_rxState)
      IDLE: begin
        w_rxClear = 1'b1;
        if (r_rxSync == START_BIT) w_rxNext = START;
      end
      START: begin
        if (w_rxTickMid) begin
          w_rxClear = 1'b1;
          w_rxNext  = (r_rxSync == START_BIT) ? DATA : IDLE;
        end
      end
      DATA: begin
        if (w_rxTickEnd) begin
          w_rxShiftEn = 1'b1;
          if (r_rxBitIdx == LAST_BIT) w_rxNext = STOP;
        end
      end
      STOP: begin
        if (w_rxTickEnd) begin
          w_rxNext    = IDLE;
          w_rxFrameOk = (r_rxSync == STOP_BIT);
        end
      end
      default: w_rxNext = IDLE;
    endcase
  end

  assign doutrx = r_doutRx;
  assign donerx = r_doneRx;

endmodule

// File: tb/tb_uart_top.sv
// Self-checking bench for uart_top: TX waveforms and RX results are compared
// against an arithmetic model of the 8N1 frame.
module tb_uart_top;

  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 9600;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int FRAME    = 10 * CPB;
  localparam int TAIL     = 200;

  logic       clk   = 1'b0;
  logic       rst   = 1'b0;
  logic       rx    = 1'b1;
  logic       send  = 1'b0;
  logic [7:0] dintx = 8'h00;
  logic       tx, donetx, donerx;
  logic [7:0] doutrx;

  int checks   = 0;
  int failures = 0;

  logic [7:0] expDout = 8'h00;

  logic       txTrace[$];
  int         doneTxAt[$];
  int         doneRxCount;
  int         doneRxAt;
  logic [7:0] doneRxVal;

  uart_top #(.clk_freq(CLK_FREQ), .baud_rate(BAUD)) dut (
    .clk   (clk),
    .rst   (rst),
    .rx    (rx),
    .dintx (dintx),
    .send  (send),
    .tx    (tx),
    .doutrx(doutrx),
    .donetx(donetx),
    .donerx(donerx)
  );

  always #5 clk = ~clk;

  // Line level of an 8N1 frame at cycle offset pos from the start-bit edge.
  function automatic logic frameLevel(input logic [7:0] b, input logic stopBit, input int pos);
    int bitNo;
    bitNo = pos / CPB;
    if (bitNo == 0) return 1'b0;
    if (bitNo <= 8) return b[bitNo-1];
    if (bitNo == 9) return stopBit;
    return 1'b1;
  endfunction

  function automatic int countTxErrors(input logic [7:0] b, input int base, input int bitNo);
    int bad;
    bad = 0;
    for (int c = 0; c < CPB; c++)
      if (txTrace[base + bitNo*CPB + c] !== frameLevel(b, 1'b1, bitNo*CPB + c)) bad++;
    return bad;
  endfunction

  // Records tx and donetx for nCycles cycles, optionally disturbing the inputs.
  task automatic capture_tx(input int nCycles, input int sendDropAt, input int changeAt,
                            input logic [7:0] newByte, input bit scramble);
    txTrace.delete();
    doneTxAt.delete();
    for (int k = 1; k <= nCycles; k++) begin
      @(negedge clk);
      txTrace.push_back(tx);
      if (donetx) doneTxAt.push_back(k);
      if (k == sendDropAt) send = 1'b0;
      if (k == changeAt) dintx = newByte;
      else if (scramble) dintx = 8'($urandom);
    end
  endtask

  // Drives one rx frame (or a low glitch of glitchLen cycles) and records donerx.
  task automatic drive_rx_frame(input logic [7:0] b, input logic stopBit, input int glitchLen);
    int total;
    total = ((glitchLen > 0) ? glitchLen : FRAME) + TAIL;
    doneRxCount = 0;
    doneRxAt    = -1;
    doneRxVal   = 8'h00;
    for (int k = 0; k < total; k++) begin
      @(negedge clk);
      if (donerx) begin
        doneRxCount++;
        if (doneRxAt < 0) begin
          doneRxAt  = k;
          doneRxVal = doutrx;
        end
      end
      if (glitchLen > 0) rx = (k < glitchLen) ? 1'b0 : 1'b1;
      else               rx = frameLevel(b, stopBit, k);
    end
    rx = 1'b1;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin failures++; $display("[TB] FAIL reset_tx: got %b want 1", tx); end
    checks++;
    if (donetx !== 1'b0) begin failures++; $display("[TB] FAIL reset_donetx: got %b want 0", donetx); end
    checks++;
    if (donerx !== 1'b0) begin failures++; $display("[TB] FAIL reset_donerx: got %b want 0", donerx); end
    checks++;
    if (doutrx !== 8'h00) begin failures++; $display("[TB] FAIL reset_doutrx: got %h want 00", doutrx); end
    rst = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || donetx !== 1'b0 || donerx !== 1'b0)
      begin failures++; $display("[TB] FAIL idle_after_reset: tx=%b donetx=%b donerx=%b want 1/0/0", tx, donetx, donerx); end
  endtask

  task automatic test_tx_single(input logic [7:0] b);
    int bad;
    int firstDone;
    @(negedge clk);
    dintx = b;
    send  = 1'b1;
    capture_tx(FRAME + TAIL, 60, 0, 8'h00, 1'b1);
    for (int bitNo = 0; bitNo < 10; bitNo++) begin
      bad = countTxErrors(b, 0, bitNo);
      checks++;
      if (bad != 0) begin
        failures++;
        $display("[TB] FAIL tx_bit%0d byte=%h: %0d wrong cycles, want level %b", bitNo, b, bad,
                 frameLevel(b, 1'b1, bitNo*CPB));
      end
    end
    firstDone = (doneTxAt.size() > 0) ? doneTxAt[0] : -1;
    checks++;
    if (doneTxAt.size() != 1 || firstDone != FRAME) begin
      failures++;
      $display("[TB] FAIL donetx_pulse byte=%h: %0d pulses first at %0d, want 1 at %0d",
               b, doneTxAt.size(), firstDone, FRAME);
    end
    bad = 0;
    for (int k = FRAME; k < FRAME + TAIL; k++) if (txTrace[k] !== 1'b1) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("[TB] FAIL tx_idle_after byte=%h: %0d low cycles, want 0", b, bad); end
  endtask

  task automatic test_back_to_back(input logic [7:0] b1, input logic [7:0] b2);
    int bad;
    int d0, d1;
    logic [7:0] exp;
    @(negedge clk);
    dintx = b1;
    send  = 1'b1;
    capture_tx(2*FRAME + TAIL, FRAME + 60, 500, b2, 1'b0);
    for (int f = 0; f < 2; f++) begin
      exp = (f == 0) ? b1 : b2;
      bad = 0;
      for (int bitNo = 0; bitNo < 10; bitNo++) bad += countTxErrors(exp, f*FRAME, bitNo);
      checks++;
      if (bad != 0) begin failures++; $display("[TB] FAIL b2b_frame%0d byte=%h: %0d wrong cycles, want 0", f, exp, bad); end
    end
    d0 = (doneTxAt.size() > 0) ? doneTxAt[0] : -1;
    d1 = (doneTxAt.size() > 1) ? doneTxAt[1] : -1;
    checks++;
    if (doneTxAt.size() != 2 || d0 != FRAME || d1 != 2*FRAME) begin
      failures++;
      $display("[TB] FAIL b2b_donetx: %0d pulses at %0d,%0d want 2 at %0d,%0d",
               doneTxAt.size(), d0, d1, FRAME, 2*FRAME);
    end
    bad = 0;
    for (int k = 2*FRAME; k < 2*FRAME + TAIL; k++) if (txTrace[k] !== 1'b1) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("[TB] FAIL b2b_idle_after: %0d low cycles, want 0", bad); end
  endtask

  task automatic test_rx_frame(input logic [7:0] b, input logic stopBit);
    int centre;
    centre = 9*CPB + CPB/2;
    @(negedge clk);
    drive_rx_frame(b, stopBit, 0);
    if (stopBit) expDout = b;
    checks++;
    if (doneRxCount != (stopBit ? 1 : 0)) begin
      failures++;
      $display("[TB] FAIL rx_donerx_count byte=%h stop=%b: got %0d want %0d", b, stopBit, doneRxCount, stopBit ? 1 : 0);
    end
    if (stopBit) begin
      checks++;
      if (doneRxAt <= centre || doneRxAt > centre + 5) begin
        failures++;
        $display("[TB] FAIL rx_donerx_time byte=%h: at %0d want %0d..%0d", b, doneRxAt, centre + 1, centre + 5);
      end
      checks++;
      if (doneRxVal !== b) begin failures++; $display("[TB] FAIL rx_data_at_done: got %h want %h", doneRxVal, b); end
    end
    checks++;
    if (doutrx !== expDout) begin failures++; $display("[TB] FAIL rx_doutrx byte=%h stop=%b: got %h want %h", b, stopBit, doutrx, expDout); end
  endtask

  task automatic test_rx_glitch;
    @(negedge clk);
    drive_rx_frame(8'h00, 1'b1, 30);
    checks++;
    if (doneRxCount != 0) begin failures++; $display("[TB] FAIL rx_glitch_donerx: got %0d pulses want 0", doneRxCount); end
    checks++;
    if (doutrx !== expDout) begin failures++; $display("[TB] FAIL rx_glitch_doutrx: got %h want %h", doutrx, expDout); end
  endtask

  task automatic test_rx_random;
    logic [7:0] b;
    logic       s;
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      s = ($urandom_range(0, 3) != 0);
      test_rx_frame(b, s);
    end
  endtask

  task automatic test_full_duplex(input logic [7:0] bt, input logic [7:0] br);
    int bad;
    int firstDone;
    @(negedge clk);
    dintx = bt;
    send  = 1'b1;
    fork
      capture_tx(FRAME + TAIL, 20, 0, 8'h00, 1'b1);
      drive_rx_frame(br, 1'b1, 0);
    join
    expDout = br;
    bad = 0;
    for (int bitNo = 0; bitNo < 10; bitNo++) bad += countTxErrors(bt, 0, bitNo);
    checks++;
    if (bad != 0) begin failures++; $display("[TB] FAIL duplex_tx byte=%h: %0d wrong cycles, want 0", bt, bad); end
    firstDone = (doneTxAt.size() > 0) ? doneTxAt[0] : -1;
    checks++;
    if (doneTxAt.size() != 1 || firstDone != FRAME) begin
      failures++;
      $display("[TB] FAIL duplex_donetx: %0d pulses first at %0d want 1 at %0d", doneTxAt.size(), firstDone, FRAME);
    end
    checks++;
    if (doneRxCount != 1 || doutrx !== br)
      begin failures++; $display("[TB] FAIL duplex_rx: %0d pulses doutrx=%h want 1 pulse and %h", doneRxCount, doutrx, br); end
  endtask

  task automatic test_reset_mid_frame;
    int pulses;
    @(negedge clk);
    dintx = 8'($urandom);
    send  = 1'b1;
    rx    = 1'b0;
    repeat (50) @(negedge clk);
    send = 1'b0;
    checks++;
    if (tx !== 1'b0) begin failures++; $display("[TB] FAIL tx_before_reset: got %b want 0", tx); end
    rst = 1'b0;
    #1;
    expDout = 8'h00;
    checks++;
    if (tx !== 1'b1) begin failures++; $display("[TB] FAIL async_reset_tx: got %b want 1", tx); end
    checks++;
    if (donetx !== 1'b0 || donerx !== 1'b0)
      begin failures++; $display("[TB] FAIL async_reset_done: donetx=%b donerx=%b want 0/0", donetx, donerx); end
    checks++;
    if (doutrx !== 8'h00) begin failures++; $display("[TB] FAIL async_reset_doutrx: got %h want 00", doutrx); end
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int k = 0; k < 2*CPB; k++) begin
      @(negedge clk);
      if (donetx || donerx || tx !== 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin failures++; $display("[TB] FAIL post_reset_quiet: %0d active cycles want 0", pulses); end
  endtask

  initial begin
    test_reset;
    test_tx_single(8'hAA);
    test_back_to_back(8'h0F, 8'($urandom));
    test_tx_single(8'($urandom));
    test_rx_frame(8'h35, 1'b1);
    test_rx_frame(8'h5A, 1'b0);
    test_rx_glitch;
    test_rx_frame(8'hC3, 1'b1);
    test_rx_random;
    test_full_duplex(8'($urandom), 8'($urandom));
    test_reset_mid_frame;
    test_tx_single(8'h81);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
